// File: rtl/apb_master.sv
// Command-to-APB bridge: accepts one read/write command, runs SETUP/ACCESS with an
// optional PREADY timeout, and returns data/error on a valid/ready response port.
module apb_master #(
  parameter int DW        = 32,
  parameter int AW        = 5,
  parameter int TO_CYCLES = 16
) (
  input  logic            pclk,
  input  logic            preset,
  input  logic            i_cmd_valid,
  output logic            o_cmd_ready,
  input  logic            i_cmd_write,
  input  logic [AW-1:0]   i_cmd_addr,
  input  logic [DW-1:0]   i_cmd_wdata,
  input  logic [DW/8-1:0] i_cmd_strb,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic [DW-1:0]   o_rsp_rdata,
  output logic            o_rsp_err,
  output logic            o_rsp_timeout,
  output logic [AW-1:0]   o_paddr,
  output logic            o_pwrite,
  output logic            o_psel,
  output logic            o_penable,
  output logic [DW-1:0]   o_pwdata,
  output logic [DW/8-1:0] o_pstrb,
  input  logic [DW-1:0]   i_prdata,
  input  logic            i_pslverr,
  input  logic            i_pready
);

  localparam int SW = DW / 8;
  // Counter keeps at least one bit so the no-timeout build still elaborates.
  localparam int            CW      = (TO_CYCLES > 0) ? $clog2(TO_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TO_CYCLES > 0) ? TO_CYCLES - 1 : 0);
  localparam bit            TO_EN   = (TO_CYCLES != 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t        state;
  logic [CW-1:0] to_cnt;

  assign o_cmd_ready = (state == IDLE) && !preset;

  always_ff @(posedge pclk) begin
    if (preset) begin
      state         <= IDLE;
      to_cnt        <= '0;
      o_psel        <= 1'b0;
      o_penable     <= 1'b0;
      o_paddr       <= '0;
      o_pwrite      <= 1'b0;
      o_pwdata      <= '0;
      o_pstrb       <= '0;
      o_rsp_valid   <= 1'b0;
      o_rsp_rdata   <= '0;
      o_rsp_err     <= 1'b0;
      o_rsp_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_cmd_valid) begin
            o_paddr   <= i_cmd_addr;
            o_pwrite  <= i_cmd_write;
            o_pwdata  <= i_cmd_wdata;
            o_pstrb   <= i_cmd_write ? i_cmd_strb : SW'(0);
            o_psel    <= 1'b1;
            o_penable <= 1'b0;
            to_cnt    <= '0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          o_penable <= 1'b1;
          state     <= ACCESS;
        end
        ACCESS: begin
          // PREADY is tested first so it wins over a coincident timeout.
          if (i_pready) begin
            o_psel        <= 1'b0;
            o_penable     <= 1'b0;
            o_rsp_rdata   <= o_pwrite ? DW'(0) : i_prdata;
            o_rsp_err     <= i_pslverr;
            o_rsp_timeout <= 1'b0;
            o_rsp_valid   <= 1'b1;
            state         <= RESP;
          end else if (TO_EN && (to_cnt == TO_LAST)) begin
            o_psel        <= 1'b0;
            o_penable     <= 1'b0;
            o_rsp_rdata   <= '0;
            o_rsp_err     <= 1'b1;
            o_rsp_timeout <= 1'b1;
            o_rsp_valid   <= 1'b1;
            state         <= RESP;
          end else begin
            to_cnt <= to_cnt + CW'(1);
          end
        end
        RESP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Scoreboard bench for apb_master: a behavioural APB slave with programmable wait
// states, expected responses queued at command time and checked on rsp_valid.
module tb_apb_master;

  logic        pclk, preset;
  logic        i_cmd_valid, o_cmd_ready, i_cmd_write;
  logic [4:0]  i_cmd_addr;
  logic [31:0] i_cmd_wdata;
  logic [3:0]  i_cmd_strb;
  logic        o_rsp_valid, i_rsp_ready;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err, o_rsp_timeout;
  logic [4:0]  o_paddr;
  logic        o_pwrite, o_psel, o_penable;
  logic [31:0] o_pwdata;
  logic [3:0]  o_pstrb;
  logic [31:0] i_prdata;
  logic        i_pslverr, i_pready;

  apb_master #(.DW(32), .AW(5), .TO_CYCLES(16)) dut (
    .pclk(pclk), .preset(preset),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_write(i_cmd_write),
    .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata), .i_cmd_strb(i_cmd_strb),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_rdata(o_rsp_rdata),
    .o_rsp_err(o_rsp_err), .o_rsp_timeout(o_rsp_timeout),
    .o_paddr(o_paddr), .o_pwrite(o_pwrite), .o_psel(o_psel), .o_penable(o_penable),
    .o_pwdata(o_pwdata), .o_pstrb(o_pstrb),
    .i_prdata(i_prdata), .i_pslverr(i_pslverr), .i_pready(i_pready)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        to;
    logic [4:0]  addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Slave configuration, written by the main sequence.
  int          s_wait  = 0;
  bit          s_hang  = 0;
  bit          s_err   = 0;
  bit          s_stale = 0;
  logic [31:0] s_rdata = '0;
  int          acc_n   = 0;

  // Slave drives completion #1 after each edge; outside a ready ACCESS cycle it
  // presents junk data and PSLVERR=1, which the master must ignore.
  always @(posedge pclk) begin
    #1;
    if (o_psel && o_penable) begin
      i_pready = !s_hang && (acc_n == s_wait);
      acc_n++;
    end else begin
      acc_n    = 0;
      i_pready = s_stale && o_psel;
    end
    i_prdata  = (o_psel && o_penable && i_pready) ? s_rdata : 32'h5151_BAD0;
    i_pslverr = (o_psel && o_penable && i_pready) ? s_err : 1'b1;
  end

  // Bus monitor: per-transfer psel/penable cycle counts and ACCESS-phase snapshot.
  int          m_psel = 0, m_pen = 0;
  logic [4:0]  m_addr;
  logic        m_wr;
  logic [31:0] m_wdata;
  logic [3:0]  m_strb;

  always @(negedge pclk) begin
    if (i_cmd_valid && o_cmd_ready) begin
      m_psel = 0;
      m_pen  = 0;
    end else begin
      if (o_psel) m_psel++;
      if (o_penable) begin
        m_pen++;
        m_addr  = o_paddr;
        m_wr    = o_pwrite;
        m_wdata = o_pwdata;
        m_strb  = o_pstrb;
      end
    end
  end

  task automatic send(input logic wr, input logic [4:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input logic [31:0] e_rdata,
                      input logic e_err, input logic e_to);
    exp_t e;
    @(posedge pclk); #1;
    i_cmd_valid = 1'b1;
    i_cmd_write = wr;
    i_cmd_addr  = addr;
    i_cmd_wdata = wdata;
    i_cmd_strb  = strb;
    @(negedge pclk);
    check("cmd_ready", o_cmd_ready, 1);
    e.rdata = e_rdata; e.err = e_err; e.to = e_to;
    e.addr = addr; e.wr = wr; e.wdata = wdata; e.strb = wr ? strb : 4'h0;
    exp_q.push_back(e);
    @(posedge pclk); #1;
    i_cmd_valid = 1'b0;
  endtask

  // Returns at the negedge where rsp_valid is first seen; exp_lat < 0 skips latency.
  task automatic get_rsp(input string tag, input int exp_lat, input int exp_psel,
                         input int exp_pen);
    exp_t e;
    int   n = 0;
    bit   seen = 0;
    while (n < 100 && !seen) begin
      @(negedge pclk);
      n++;
      seen = o_rsp_valid;
    end
    if (!seen) begin
      check({tag, "_rsp_timeout_wait"}, 0, 1);
      return;
    end
    if (exp_q.size() == 0) begin
      check({tag, "_unexpected_rsp"}, 1, 0);
      return;
    end
    e = exp_q.pop_front();
    if (exp_lat >= 0) check({tag, "_latency"}, n, exp_lat);
    check({tag, "_rdata"},   o_rsp_rdata,   e.rdata);
    check({tag, "_err"},     o_rsp_err,     e.err);
    check({tag, "_timeout"}, o_rsp_timeout, e.to);
    check({tag, "_paddr"},   m_addr,        e.addr);
    check({tag, "_pwrite"},  m_wr,          e.wr);
    check({tag, "_pwdata"},  m_wdata,       e.wdata);
    check({tag, "_pstrb"},   m_strb,        e.strb);
    check({tag, "_psel_cyc"}, m_psel,       exp_psel);
    check({tag, "_pen_cyc"},  m_pen,        exp_pen);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    preset = 1'b1; i_cmd_valid = 1'b0; i_cmd_write = 1'b0; i_cmd_addr = '0;
    i_cmd_wdata = '0; i_cmd_strb = '0; i_rsp_ready = 1'b1;
    i_prdata = '0; i_pslverr = 1'b0; i_pready = 1'b0;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    check("rst_psel",      o_psel,      0);
    check("rst_penable",   o_penable,   0);
    check("rst_rsp_valid", o_rsp_valid, 0);
    check("rst_rsp_err",   {o_rsp_err, o_rsp_timeout}, 0);
    check("rst_rsp_rdata", o_rsp_rdata, 0);
    check("rst_apb",       {o_paddr, o_pwrite, o_pwdata, o_pstrb}, 0);
    check("rst_cmd_ready", o_cmd_ready, 0);
    @(posedge pclk); #1;
    preset = 1'b0;
    @(negedge pclk);
    check("post_rst_cmd_ready", o_cmd_ready, 1);

    // 1: write, zero wait states
    s_wait = 0; s_err = 0; s_rdata = 32'h7777_7777;
    send(1'b1, 5'h08, 32'hA5A5_5A5A, 4'hF, 32'h0, 1'b0, 1'b0);
    get_rsp("wr0", 3, 2, 1);

    // 2: read, one wait state, stale PREADY during SETUP
    s_wait = 1; s_stale = 1; s_rdata = 32'hDEAD_BEEF;
    send(1'b0, 5'h0C, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0, 1'b0);
    get_rsp("rd1", 4, 3, 2);
    s_stale = 0;

    // 3: write with PSLVERR
    s_wait = 0; s_err = 1;
    send(1'b1, 5'h0C, 32'h0000_1234, 4'h3, 32'h0, 1'b1, 1'b0);
    get_rsp("wr_err", 3, 2, 1);
    s_err = 0;

    // 4: PREADY never arrives, abort after 16 ACCESS cycles
    s_hang = 1; s_rdata = 32'h1111_2222;
    send(1'b0, 5'h14, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1);
    get_rsp("tmo", 18, 17, 16);
    s_hang = 0;

    // 5: response back-pressure with a new command waiting
    s_wait = 2; s_rdata = 32'h1122_3344;
    @(posedge pclk); #1;
    i_rsp_ready = 1'b0;
    send(1'b0, 5'h04, 32'h0, 4'h0, 32'h1122_3344, 1'b0, 1'b0);
    get_rsp("bp_a", 5, 4, 3);
    s_wait = 0;
    @(posedge pclk); #1;
    i_cmd_valid = 1'b1; i_cmd_write = 1'b1; i_cmd_addr = 5'h10;
    i_cmd_wdata = 32'hCAFE_F00D; i_cmd_strb = 4'h9;
    for (int i = 0; i < 5; i++) begin
      @(negedge pclk);
      check("bp_hold", {o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_timeout},
            {1'b1, 32'h1122_3344, 1'b0, 1'b0});
      check("bp_no_accept", {o_cmd_ready, o_psel}, 0);
      @(posedge pclk); #1;
    end
    i_rsp_ready = 1'b1;
    @(posedge pclk); #1;
    begin
      exp_t e;
      e.rdata = 32'h0; e.err = 1'b0; e.to = 1'b0; e.addr = 5'h10; e.wr = 1'b1;
      e.wdata = 32'hCAFE_F00D; e.strb = 4'h9;
      @(negedge pclk);
      check("bp_b_ready", o_cmd_ready, 1);
      exp_q.push_back(e);
    end
    @(posedge pclk); #1;
    i_cmd_valid = 1'b0;
    get_rsp("bp_b", 3, 2, 1);

    // 6: reset in the second ACCESS cycle
    s_hang = 1;
    send(1'b0, 5'h18, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
    void'(exp_q.pop_back());
    @(posedge pclk); #1;
    @(posedge pclk); #1;
    preset = 1'b1;
    @(negedge pclk);
    check("mid_access", {o_psel, o_penable}, 2'b11);
    @(negedge pclk);
    check("rst_mid_bus", {o_psel, o_penable, o_rsp_valid}, 0);
    check("rst_mid_ready", o_cmd_ready, 0);
    @(posedge pclk); #1;
    preset = 1'b0; s_hang = 0;
    @(negedge pclk);
    check("rst_mid_ready_rel", o_cmd_ready, 1);
    begin
      int spurious = 0;
      for (int i = 0; i < 4; i++) begin
        @(negedge pclk);
        if (o_rsp_valid || o_psel) spurious++;
      end
      check("rst_mid_no_rsp", spurious, 0);
    end

    // recovery transfer after the interrupted one
    s_wait = 0; s_rdata = 32'h0BAD_CAFE;
    send(1'b0, 5'h1C, 32'h0, 4'hF, 32'h0BAD_CAFE, 1'b0, 1'b0);
    get_rsp("recover", 3, 2, 1);
    @(posedge pclk); #1;
    @(negedge pclk);
    check("queue_empty", exp_q.size(), 0);
    check("final_idle", {o_cmd_ready, o_rsp_valid}, 2'b10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
